// File: rtl/muxn_arb_pkg.sv
// muxn_arb shared definitions: selection modes, default sizes
// and the select-width helper used by the top and the arbiter.
package muxn_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;

    // Width of a channel index; never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant search over CHANNELS requests, starting at ptr.
// Purely combinational; the caller owns ptr and any output registers.
module rr_arbiter
    import muxn_arb_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    // Walk from farthest to nearest so the request closest to ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/muxn_arb.sv
// N:1 word selector with valid/ready handshake, fixed or round-robin
// selection and a one-entry output register. MUXN_ARB_ZERO_IDLE_EN clears
// out_data/out_chan whenever the register empties.
module muxn_arb
    import muxn_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic             load;
    logic [SEL_W-1:0] ptr;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             fix_valid;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] ptr_next;
    logic [WIDTH-1:0] gnt_word;

    assign load = !out_valid || out_ready;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Fixed mode: only an in-range sel with a valid channel is granted.
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_valid = in_valid[i];
            end
        end
    end

    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;

    // One-hot accept for the granted channel, silenced during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !reset && load && gnt_valid
                        && (gnt_idx == SEL_W'(i));
        end
    end

    // Word of the granted channel, feeds only the output register.
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (int'(gnt_idx) == CHANNELS - 1) ? '0
                    : gnt_idx + SEL_W'(1);

    // Output register and round-robin pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (gnt_valid) begin
                out_valid <= 1'b1;
                out_data  <= gnt_word;
                out_chan  <= gnt_idx;
                if (mode == MODE_RR) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
`ifdef MUXN_ARB_ZERO_IDLE_EN
                out_data  <= '0;
                out_chan  <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// Directed bench for muxn_arb: a 4x32 instance for the main features and
// a 3x8 instance to reach sel values beyond the channel count.
module tb_muxn_arb;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_chan;

    logic [23:0]  b_in_data;
    logic [2:0]   b_in_valid;
    logic [2:0]   b_in_ready;
    logic         b_mode;
    logic [1:0]   b_sel;
    logic [7:0]   b_out_data;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [1:0]   b_out_chan;

    int passed = 0;
    int total  = 0;

    muxn_arb #(.WIDTH(32), .CHANNELS(4)) dut (
        .clock     (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    muxn_arb #(.WIDTH(8), .CHANNELS(3)) dut_b (
        .clock     (clk),
        .reset     (reset),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_chan  (b_out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] chdata(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = chdata(i);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        set_data();
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_data !== 32'h0) $display("FAIL reset_data got %h want 0", out_data);
        else passed++;
        total++;
        if (in_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", in_ready);
        else passed++;
        total++;
        if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid got %b want 0", b_out_valid);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0001) $display("FAIL release_ready got %b want 0001", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== chdata(0))
            $display("FAIL release_grant got v=%b ch=%0d d=%h want v=1 ch=0 d=%h",
                     out_valid, out_chan, out_data, chdata(0));
        else passed++;
    endtask

    task automatic test_fixed();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1111;
        in_data[2*32 +: 32] = 32'hDEADBEEF;
        #1;
        total++;
        if (in_ready !== 4'b0100) $display("FAIL fixed_ready got %b want 0100", in_ready);
        else passed++;
        tick();
        total++;
        if (out_data !== 32'hDEADBEEF || out_chan !== 2'd2 || out_valid !== 1'b1)
            $display("FAIL fixed_word got v=%b ch=%0d d=%h want v=1 ch=2 d=deadbeef",
                     out_valid, out_chan, out_data);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready !== 4'b0100) $display("FAIL fixed_only_ch2 got %b want 0100", in_ready);
            else passed++;
            tick();
        end
        in_valid = 4'b1011;
        #1;
        total++;
        if (in_ready !== 4'b0000) $display("FAIL fixed_invalid_ready got %b want 0000", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL fixed_drop got %b want 0", out_valid);
        else passed++;
`ifdef MUXN_ARB_ZERO_IDLE_EN
        total++;
        if (out_data !== 32'h0 || out_chan !== 2'd0)
            $display("FAIL fixed_idle got ch=%0d d=%h want ch=0 d=0", out_chan, out_data);
        else passed++;
`else
        total++;
        if (out_data !== 32'hDEADBEEF || out_chan !== 2'd2)
            $display("FAIL fixed_idle got ch=%0d d=%h want ch=2 d=deadbeef", out_chan, out_data);
        else passed++;
`endif
        set_data();
    endtask

    task automatic test_sel_range();
        b_mode      = 1'b0;
        b_sel       = 2'd2;
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        b_in_data   = 24'h3C_A5_11;
        tick();
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h3C || b_out_chan !== 2'd2)
            $display("FAIL range_ok got v=%b ch=%0d d=%h want v=1 ch=2 d=3c",
                     b_out_valid, b_out_chan, b_out_data);
        else passed++;
        b_sel = 2'd3;
        #1;
        total++;
        if (b_in_ready !== 3'b000) $display("FAIL range_ready got %b want 000", b_in_ready);
        else passed++;
        tick();
        total++;
        if (b_out_valid !== 1'b0) $display("FAIL range_drop got %b want 0", b_out_valid);
        else passed++;
        b_in_valid = 3'b000;
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp13 [4];
        pulse_reset();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (out_chan !== 2'(k % 4) || out_data !== chdata(k % 4))
                $display("FAIL rr_all[%0d] got ch=%0d d=%h want ch=%0d",
                         k, out_chan, out_data, k % 4);
            else passed++;
        end
        exp13[0] = 2'd1;
        exp13[1] = 2'd3;
        exp13[2] = 2'd1;
        exp13[3] = 2'd3;
        pulse_reset();
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (out_chan !== exp13[k] || out_valid !== 1'b1)
                $display("FAIL rr_13[%0d] got ch=%0d v=%b want ch=%0d",
                         k, out_chan, out_valid, exp13[k]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b1111;
        tick();
        total++;
        if (out_chan !== 2'd0) $display("FAIL bp_first got ch=%0d want 0", out_chan);
        else passed++;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1
                || out_chan !== 2'd0 || out_data !== chdata(0))
                $display("FAIL bp_hold[%0d] got r=%b v=%b ch=%0d d=%h want r=0000 v=1 ch=0",
                         k, in_ready, out_valid, out_chan, out_data);
            else passed++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== chdata(1))
            $display("FAIL bp_release got v=%b ch=%0d d=%h want v=1 ch=1",
                     out_valid, out_chan, out_data);
        else passed++;
    endtask

    task automatic test_mode_switch();
        mode = 1'b0;
        sel  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (out_chan !== 2'd0 || out_valid !== 1'b1)
                $display("FAIL ms_fixed[%0d] got ch=%0d v=%b want ch=0 v=1",
                         k, out_chan, out_valid);
            else passed++;
        end
        mode = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) $display("FAIL ms_rr_ready got %b want 0100", in_ready);
        else passed++;
        tick();
        total++;
        if (out_chan !== 2'd2) $display("FAIL ms_rr_grant got ch=%0d want 2", out_chan);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) $display("FAIL rmid_ready got %b want 0000", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0)
            $display("FAIL rmid_clear got v=%b ch=%0d d=%h want v=0 ch=0 d=0",
                     out_valid, out_chan, out_data);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0001) $display("FAIL rmid_ptr got %b want 0001", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== chdata(0))
            $display("FAIL rmid_next got v=%b ch=%0d d=%h want v=1 ch=0",
                     out_valid, out_chan, out_data);
        else passed++;
    endtask

    task automatic test_idle();
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        tick();
        total++;
        if (out_chan !== 2'd1 || out_data !== chdata(1))
            $display("FAIL idle_load got ch=%0d d=%h want ch=1", out_chan, out_data);
        else passed++;
        in_valid = 4'b0000;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", out_valid);
        else passed++;
`ifdef MUXN_ARB_ZERO_IDLE_EN
        total++;
        if (out_data !== 32'h0 || out_chan !== 2'd0)
            $display("FAIL idle_value got ch=%0d d=%h want ch=0 d=0", out_chan, out_data);
        else passed++;
`else
        total++;
        if (out_data !== chdata(1) || out_chan !== 2'd1)
            $display("FAIL idle_value got ch=%0d d=%h want ch=1 d=%h",
                     out_chan, out_data, chdata(1));
        else passed++;
`endif
    endtask

    initial begin
        reset       = 1'b1;
        in_data     = '0;
        in_valid    = '0;
        mode        = 1'b0;
        sel         = '0;
        out_ready   = 1'b0;
        b_in_data   = '0;
        b_in_valid  = '0;
        b_mode      = 1'b0;
        b_sel       = '0;
        b_out_ready = 1'b1;
        test_reset();
        test_fixed();
        test_sel_range();
        test_rr_fair();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
